upct_update_arb: RTL and testbench
==================================

Name: upct_update_arb

Overview:
- Arbitrates install/lookup requests from NUM_REQ front-end requesters (e.g. BTB install, decode redirect, mispredict restart) onto the single update port of the upper PC table.
- Sequences the table's 2-stage update flow. The request is issued on update0 in cycle N; the table returns the index on update1 in cycle N+1. The arbiter routes that index back to the originating requester.
- Coalesces same-upper-PC requests against the in-flight update. This prevents duplicate table entries being installed by back-to-back misses.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- UPPER_PC_WIDTH, core_types_pkg UPPER_PC_WIDTH (10), upper PC bits tracked by the table.
- LOG_UPCT_ENTRIES, core_types_pkg LOG_UPCT_ENTRIES (3), table index width.

Ports:
- CLK  input  1  clock; single clock domain.
- RST  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_target_full_PC  input  NUM_REQ x 32  per-requester full target PC.
- req_ready  output  NUM_REQ  request accepted this cycle (granted or coalesced).
- resp_valid  output  NUM_REQ  one-hot or multi-hot; index delivered this cycle.
- resp_upct_index  output  LOG_UPCT_ENTRIES  index shared by all asserted resp_valid bits.
- upct_update0_valid  output  1  drives table update0_valid.
- upct_update0_target_full_PC  output  32  drives table update0_target_full_PC.
- upct_update1_upct_index  input  LOG_UPCT_ENTRIES  table update1_upct_index.

Behaviour:
- Reset (RST=1 at posedge): rr_ptr=0, inflight_valid=0, inflight_id=0, inflight_upper_PC=0.
  - All outputs are 0 while inflight_valid=0 and no requests are present.
  - Reset mid-flight drops the in-flight response: no resp_valid in the following cycle. The table-side install still completes.
- Upper PC of a request = req_target_full_PC[i][31:32-UPPER_PC_WIDTH].
- Requester protocol:
  - Once req_valid is high, the requester holds it and its PC stable until req_ready.
  - req_ready may depend combinationally on req_valid.
  - A request is accepted on the cycle that req_valid & req_ready are both high.
- In-flight register: loaded on every grant with inflight_valid=1, inflight_id=g and inflight_upper_PC. inflight_valid clears in a cycle with no grant.
- Response (cycle N+1 after a grant in cycle N):
  - resp_valid[inflight_id]=1.
  - resp_upct_index = upct_update1_upct_index.
- Coalesce (combinational, cycle N+1): every requester i with req_valid[i] and upper PC == inflight_upper_PC, while inflight_valid=1, gets:
  - req_ready[i]=1 and resp_valid[i]=1 in that same cycle, with the same resp_upct_index (0-cycle latency).
  - No update0 issue and no rr_ptr change for that requester.
  - This holds whether the in-flight update hits or misses.
- Grant (every cycle):
  - Candidates = req_valid & ~coalesced.
  - Round-robin: the first candidate at or after rr_ptr (wrapping modulo NUM_REQ) wins g.
  - On a grant: req_ready[g]=1, upct_update0_valid=1, upct_update0_target_full_PC = req PC[g], rr_ptr <= (g+1) mod NUM_REQ.
  - With no candidate: upct_update0_valid=0, PC output=0, rr_ptr holds.
- Throughput: one grant per cycle sustained. Different upper PCs issue back-to-back with no bubble.
- Simultaneous events in one cycle are allowed: a response for the in-flight id, coalesced acceptances, and a new grant. If the new grant is the same requester as inflight_id, both resp_valid and req_ready are asserted for it.
- Eligibility of a requester with the same upper PC as the in-flight update is decided by the coalesce rule, never by grant.
- No storage beyond rr_ptr and the in-flight register. No credit or backpressure from the table, which accepts every cycle.

Test Plan:
- Reset, then req_valid[1] with PC 0x8000_1234 (upper 0x200):
  - Cycle 0: req_ready[1]=1, update0_valid=1, PC=0x8000_1234.
  - Cycle 1: table returns 5; required resp_valid=0b0010, resp_upct_index=5.
- All 4 requesters valid continuously with distinct upper PCs, rr_ptr=0: grants in order 0,1,2,3,0. Each response arrives exactly 1 cycle after its grant with the table index forwarded.
- Req0 PC 0x8000_0000 granted in cycle 0; req2 raises PC 0x8000_0FFC (same upper 0x200) in cycle 1; table returns 3 in cycle 1:
  - Required in cycle 1: req_ready[2]=1, resp_valid=0b0101, index 3.
  - No update0 is issued for req2.
- Same upper PC raised in cycle 2 instead (no longer in flight): a normal grant is issued with update0_valid=1, and the response arrives in cycle 3.
- Req3 granted in cycle 0; RST=1 in cycle 1:
  - Cycle 1: no resp_valid.
  - Cycle 2: all outputs 0, rr_ptr=0.
  - Next grant with all requests valid goes to requester 0.
- No requests for 10 cycles: update0_valid=0, resp_valid=0, rr_ptr unchanged throughout.

Source files
------------

// File: rtl/upct_update_arb.sv
// upct_update_arb: round-robin arbiter onto the upper PC table's 2-stage update port.
// Routes the returned index to the issuing requester and coalesces same-upper-PC requests.
module upct_update_arb #(
  parameter int NUM_REQ          = 4,
  parameter int UPPER_PC_WIDTH   = 10,
  parameter int LOG_UPCT_ENTRIES = 3
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][31:0]           req_target_full_PC,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic [LOG_UPCT_ENTRIES-1:0]        resp_upct_index,
  output logic                               upct_update0_valid,
  output logic [31:0]                        upct_update0_target_full_PC,
  input  logic [LOG_UPCT_ENTRIES-1:0]        upct_update1_upct_index
);

  localparam int              ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]           rr_ptr;
  logic                      inflight_valid;
  logic [ID_W-1:0]           inflight_id;
  logic [UPPER_PC_WIDTH-1:0] inflight_upper_PC;

  logic                      inflight_resp;
  logic [NUM_REQ-1:0]        coalesced;
  logic [NUM_REQ-1:0]        candidates;
  logic                      grant_valid;
  logic [ID_W-1:0]           grant_id;
  logic [ID_W:0]             scan_idx;
  logic [NUM_REQ-1:0]        grant_mask;
  logic [NUM_REQ-1:0]        inflight_mask;
  logic [ID_W-1:0]           rr_next;

  // A reset cycle suppresses the pending response and any new acceptance, since
  // the registers that would track them are being cleared at the same edge.
  always_comb begin
    inflight_resp = inflight_valid & ~RST;
    coalesced     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      coalesced[i] = inflight_resp & req_valid[i] &
                     (req_target_full_PC[i][31 -: UPPER_PC_WIDTH] == inflight_upper_PC);
    end
    candidates = RST ? '0 : (req_valid & ~coalesced);
  end

  // Scan starting at rr_ptr, wrapping modulo NUM_REQ; first candidate wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_idx >= NUM_REQ_W) begin
        scan_idx = scan_idx - NUM_REQ_W;
      end
      if (!grant_valid && candidates[scan_idx[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant_mask    = '0;
    inflight_mask = '0;
    if (grant_valid) begin
      grant_mask[grant_id] = 1'b1;
    end
    if (inflight_resp) begin
      inflight_mask[inflight_id] = 1'b1;
    end
    rr_next = (grant_id == LAST_ID) ? '0 : (grant_id + 1'b1);
  end

  always_comb begin
    req_ready                   = grant_mask | coalesced;
    resp_valid                  = inflight_mask | coalesced;
    resp_upct_index             = inflight_resp ? upct_update1_upct_index : '0;
    upct_update0_valid          = grant_valid;
    upct_update0_target_full_PC = grant_valid ? req_target_full_PC[grant_id] : 32'h0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr            <= '0;
      inflight_valid    <= 1'b0;
      inflight_id       <= '0;
      inflight_upper_PC <= '0;
    end else begin
      inflight_valid <= grant_valid;
      if (grant_valid) begin
        rr_ptr            <= rr_next;
        inflight_id       <= grant_id;
        inflight_upper_PC <= req_target_full_PC[grant_id][31 -: UPPER_PC_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_upct_update_arb.sv
// tb_upct_update_arb: cycle vector table for upct_update_arb, followed by a
// sustained round-robin stream whose responses are tracked through a scoreboard queue.
module tb_upct_update_arb;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [3:0]        req_valid = '0;
  logic [3:0][31:0]  req_target_full_PC = '0;
  logic [3:0]        req_ready;
  logic [3:0]        resp_valid;
  logic [2:0]        resp_upct_index;
  logic              upct_update0_valid;
  logic [31:0]       upct_update0_target_full_PC;
  logic [2:0]        upct_update1_upct_index = '0;

  int checks = 0;
  int errors = 0;

  upct_update_arb #(.NUM_REQ(4), .UPPER_PC_WIDTH(10), .LOG_UPCT_ENTRIES(3)) dut (
    .CLK                         (CLK),
    .RST                         (RST),
    .req_valid                   (req_valid),
    .req_target_full_PC          (req_target_full_PC),
    .req_ready                   (req_ready),
    .resp_valid                  (resp_valid),
    .resp_upct_index             (resp_upct_index),
    .upct_update0_valid          (upct_update0_valid),
    .upct_update0_target_full_PC (upct_update0_target_full_PC),
    .upct_update1_upct_index     (upct_update1_upct_index)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] pc0, pc1, pc2, pc3;
    logic [2:0]  tbl;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic [2:0]  idx;
    logic        u0v;
    logic [31:0] u0pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [3:0] rv, logic [31:0] pc0, logic [31:0] pc1,
                              logic [31:0] pc2, logic [31:0] pc3, logic [2:0] tbl,
                              logic [3:0] rdy, logic [3:0] rsp, logic [2:0] idx,
                              logic u0v, logic [31:0] u0pc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.pc0 = pc0; v.pc1 = pc1; v.pc2 = pc2; v.pc3 = pc3;
    v.tbl = tbl; v.rdy = rdy; v.rsp = rsp; v.idx = idx; v.u0v = u0v; v.u0pc = u0pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [31:0] cur_pc[4];
  int          exp_q[$];
  int          rr_m;
  int          seq;
  int          id;

  initial begin
    //          rst rv      pc0           pc1           pc2           pc3           tbl  rdy     rsp     idx  u0v u0pc
    vecs.push_back(mk(1, 4'b0000, 0,            0,            0,            0,            0, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            0, 4'b0000, 4'b0000, 0, 0, 0));
    // single request, index returned next cycle
    vecs.push_back(mk(0, 4'b0010, 0,            32'h8000_1234, 0,           0,            0, 4'b0010, 4'b0000, 0, 1, 32'h8000_1234));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            5, 4'b0000, 4'b0010, 5, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 0,            0,            0,            0,            0, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            0, 4'b0000, 4'b0000, 0, 0, 0));
    // all valid, distinct uppers: grants 0,1,2,3,0
    vecs.push_back(mk(0, 4'b1111, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000, 0, 4'b0001, 4'b0000, 0, 1, 32'h1000_0000));
    vecs.push_back(mk(0, 4'b1111, 32'h5000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000, 1, 4'b0010, 4'b0001, 1, 1, 32'h2000_0000));
    vecs.push_back(mk(0, 4'b1111, 32'h5000_0000, 32'h6000_0000, 32'h3000_0000, 32'h4000_0000, 2, 4'b0100, 4'b0010, 2, 1, 32'h3000_0000));
    vecs.push_back(mk(0, 4'b1111, 32'h5000_0000, 32'h6000_0000, 32'h7000_0000, 32'h4000_0000, 3, 4'b1000, 4'b0100, 3, 1, 32'h4000_0000));
    vecs.push_back(mk(0, 4'b1111, 32'h5000_0000, 32'h6000_0000, 32'h7000_0000, 32'h9000_0000, 4, 4'b0001, 4'b1000, 4, 1, 32'h5000_0000));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            6, 4'b0000, 4'b0001, 6, 0, 0));
    // coalesce against in-flight upper 0x200
    vecs.push_back(mk(0, 4'b0001, 32'h8000_0000, 0,           0,            0,            0, 4'b0001, 4'b0000, 0, 1, 32'h8000_0000));
    vecs.push_back(mk(0, 4'b0100, 0,            0,            32'h8000_0FFC, 0,           3, 4'b0100, 4'b0101, 3, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            7, 4'b0000, 4'b0000, 0, 0, 0));
    // same upper two cycles later: normal grant
    vecs.push_back(mk(0, 4'b0001, 32'h8000_0000, 0,           0,            0,            0, 4'b0001, 4'b0000, 0, 1, 32'h8000_0000));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            2, 4'b0000, 4'b0001, 2, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 0,            0,            32'h8000_0FFC, 0,           0, 4'b0100, 4'b0000, 0, 1, 32'h8000_0FFC));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            6, 4'b0000, 4'b0100, 6, 0, 0));
    // reset while requester 3 is in flight
    vecs.push_back(mk(0, 4'b1000, 0,            0,            0,            32'h1234_5678, 0, 4'b1000, 4'b0000, 0, 1, 32'h1234_5678));
    vecs.push_back(mk(1, 4'b0000, 0,            0,            0,            0,            5, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            5, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000, 0, 4'b0001, 4'b0000, 0, 1, 32'h1000_0000));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            1, 4'b0000, 4'b0001, 1, 0, 0));
    // ten idle cycles; pointer must still be at 1 afterwards
    for (int n = 0; n < 10; n++)
      vecs.push_back(mk(0, 4'b0000, 0,          0,            0,            0,            3'(n), 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000, 0, 4'b0010, 4'b0000, 0, 1, 32'h2000_0000));
    // response, coalesce and new grant in one cycle
    vecs.push_back(mk(0, 4'b1111, 32'h1000_0000, 32'h2000_0FFF, 32'h3000_0000, 32'h4000_0000, 4, 4'b0110, 4'b0010, 4, 1, 32'h3000_0000));
    vecs.push_back(mk(0, 4'b1101, 32'h1000_0000, 0,            32'h7000_0000, 32'h4000_0000, 5, 4'b1000, 4'b0100, 5, 1, 32'h4000_0000));
    vecs.push_back(mk(0, 4'b0101, 32'h1000_0000, 0,            32'h7000_0000, 0,            6, 4'b0001, 4'b1000, 6, 1, 32'h1000_0000));
    vecs.push_back(mk(0, 4'b0100, 0,            0,            32'h7000_0000, 0,            7, 4'b0100, 4'b0001, 7, 1, 32'h7000_0000));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            0, 4'b0000, 4'b0100, 0, 0, 0));
    // same requester granted while its previous update responds
    vecs.push_back(mk(0, 4'b0010, 0,            32'h2000_0000, 0,           0,            0, 4'b0010, 4'b0000, 0, 1, 32'h2000_0000));
    vecs.push_back(mk(0, 4'b0010, 0,            32'hA000_0000, 0,           0,            3, 4'b0010, 4'b0010, 3, 1, 32'hA000_0000));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            2, 4'b0000, 4'b0010, 2, 0, 0));
    // multi-hot coalesce alongside a grant
    vecs.push_back(mk(0, 4'b0001, 32'hC000_0000, 0,           0,            0,            0, 4'b0001, 4'b0000, 0, 1, 32'hC000_0000));
    vecs.push_back(mk(0, 4'b1110, 0,            32'hC000_0100, 32'h5000_0000, 32'hC000_0200, 6, 4'b1110, 4'b1011, 6, 1, 32'h5000_0000));
    vecs.push_back(mk(0, 4'b0000, 0,            0,            0,            0,            1, 4'b0000, 4'b0100, 1, 0, 0));

    @(posedge CLK);
    @(posedge CLK);
    foreach (vecs[n]) begin
      @(posedge CLK);
      #1;
      RST = vecs[n].rst;
      req_valid = vecs[n].rv;
      req_target_full_PC[0] = vecs[n].pc0;
      req_target_full_PC[1] = vecs[n].pc1;
      req_target_full_PC[2] = vecs[n].pc2;
      req_target_full_PC[3] = vecs[n].pc3;
      upct_update1_upct_index = vecs[n].tbl;
      @(negedge CLK);
      check($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(vecs[n].rdy));
      check($sformatf("v%0d resp_valid", n), 32'(resp_valid), 32'(vecs[n].rsp));
      check($sformatf("v%0d resp_upct_index", n), 32'(resp_upct_index), 32'(vecs[n].idx));
      check($sformatf("v%0d update0_valid", n), 32'(upct_update0_valid), 32'(vecs[n].u0v));
      check($sformatf("v%0d update0_pc", n), upct_update0_target_full_PC, vecs[n].u0pc);
    end

    // sustained stream: all requesters always valid, fresh distinct upper PC after each grant
    @(posedge CLK);
    #1;
    RST = 1'b1;
    req_valid = '0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    rr_m = 0;
    seq = 1;
    for (int i = 0; i < 4; i++) begin
      cur_pc[i] = {10'(seq), 22'($urandom)};
      seq++;
    end
    for (int c = 0; c < 30; c++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_target_full_PC[i] = cur_pc[i];
      upct_update1_upct_index = 3'($urandom_range(0, 7));
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        id = exp_q.pop_front();
        check($sformatf("s%0d resp_valid", c), 32'(resp_valid), 32'(1) << id);
        check($sformatf("s%0d resp_upct_index", c), 32'(resp_upct_index), 32'(upct_update1_upct_index));
      end else begin
        check($sformatf("s%0d resp_valid idle", c), 32'(resp_valid), 32'h0);
      end
      check($sformatf("s%0d req_ready", c), 32'(req_ready), 32'(1) << rr_m);
      check($sformatf("s%0d update0_valid", c), 32'(upct_update0_valid), 32'h1);
      check($sformatf("s%0d update0_pc", c), upct_update0_target_full_PC, cur_pc[rr_m]);
      exp_q.push_back(rr_m);
      cur_pc[rr_m] = {10'(seq), 22'($urandom)};
      seq++;
      rr_m = (rr_m + 1) % 4;
      @(posedge CLK);
      #1;
    end
    req_valid = '0;
    upct_update1_upct_index = 3'($urandom_range(0, 7));
    @(negedge CLK);
    check("stream tail pending", 32'(exp_q.size()), 32'h1);
    if (exp_q.size() > 0) begin
      id = exp_q.pop_front();
      check("stream tail resp_valid", 32'(resp_valid), 32'(1) << id);
      check("stream tail resp_upct_index", 32'(resp_upct_index), 32'(upct_update1_upct_index));
    end
    check("stream tail update0_valid", 32'(upct_update0_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
